mole_auto_player: RTL and testbench



---
 rtl/mole_auto_player.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mole_auto_player.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mole_auto_player.sv
// mole_auto_player: closed-loop stimulus agent for the whack-a-mole game.
// Watches the game's active-low 7-segment bus, presses the button matching the lit
// segment long enough to pass the game's debouncer, and at game over decodes the hex
// score digit shown on the display and compares it with the score bus.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              agent enable; low forces IDLE with buttons released
//   seg_in, dp_in   game display (active-low segments; dp 1 = playing, 0 = game over)
//   score_in        game score bus (low nibble compared against the decoded digit)
//   miss_en         press the neighbouring button instead of the target
//   auto_restart    press pb0 after a successful game-over decode
//   btn_out         registered button drive, at most one bit high
//   busy            agent not idle
//   hits, misses    saturating counts of correct / deliberately wrong presses
//   final_score     decoded game-over digit, qualified by score_valid
//   score_mismatch  decoded digit differed from score_in[3:0]
//   decode_err      one-cycle pulse on an illegal segment pattern
module mole_auto_player #(
  parameter int unsigned REACT_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES  = 6,
  parameter int unsigned GAP_CYCLES   = 6,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic [7:0] score_in,
  input  logic       miss_en,
  input  logic       auto_restart,
  output logic [7:0] btn_out,
  output logic       busy,
  output logic [7:0] hits,
  output logic [7:0] misses,
  output logic [3:0] final_score,
  output logic       score_valid,
  output logic       score_mismatch,
  output logic       decode_err
);

  typedef enum logic [2:0] {
    StIdle, StWatch, StReact, StPress, StRelease, StOver, StRestart
  } state_e;

  localparam logic [CNT_W-1:0] ReactLast   = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RestartLast = CNT_W'(HOLD_CYCLES + GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       target_q, target_d;
  logic [6:0]       pat_q, pat_d;
  logic [6:0]       prev_seg_q;
  logic [7:0]       btn_q, btn_d;
  logic [7:0]       hits_q, hits_d;
  logic [7:0]       misses_q, misses_d;
  logic [3:0]       final_q, final_d;
  logic             valid_q, valid_d;
  logic             mismatch_q, mismatch_d;
  logic             err_q, err_d;
  logic             done_q, done_d;  // game-over digit decoded for this OVER entry
  logic             bad_q, bad_d;    // pat_q holds a pattern that already failed to decode

  logic unused_score_hi;
  assign unused_score_hi = ^score_in[7:4];

  function automatic logic [2:0] zero_count(input logic [6:0] s);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) c = c + {2'b00, ~s[i]};
    return c;
  endfunction

  function automatic logic [2:0] zero_index(input logic [6:0] s);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 7; i++) if (!s[i]) idx = 3'(i);
    return idx;
  endfunction

  // Returns {legal, digit}.
  function automatic logic [4:0] hex_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [2:0] zeros;
  logic [2:0] miss_tgt;
  logic [4:0] hex;
  logic       in_play;

  assign zeros    = zero_count(seg_in);
  assign miss_tgt = (target_q == 3'd6) ? 3'd0 : target_q + 3'd1;
  assign hex      = hex_decode(seg_in);
  assign in_play  = (state_q == StWatch) || (state_q == StReact) ||
                    (state_q == StPress) || (state_q == StRelease);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    pat_d      = pat_q;
    btn_d      = btn_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    final_d    = final_q;
    valid_d    = valid_q;
    mismatch_d = mismatch_q;
    err_d      = 1'b0;
    done_d     = done_q;
    bad_d      = bad_q;

    if (!en) begin
      state_d = StIdle;
      btn_d   = 8'h00;
    end else if (!dp_in && in_play) begin
      state_d    = StOver;
      btn_d      = 8'h00;
      done_d     = 1'b0;
      bad_d      = 1'b0;
      valid_d    = 1'b0;
      mismatch_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          btn_d   = 8'h00;
          state_d = StWatch;
        end
        StWatch: begin
          if (zeros == 3'd1) begin
            target_d = zero_index(seg_in);
            pat_d    = seg_in;
            cnt_d    = '0;
            state_d  = StReact;
          end else if (zeros != 3'd0) begin
            err_d = 1'b1;
          end
        end
        StReact: begin
          if (seg_in != pat_q) begin
            state_d = StWatch;
          end else if (cnt_q == ReactLast) begin
            state_d = StPress;
            cnt_d   = '0;
            if (miss_en) begin
              btn_d = 8'h01 << miss_tgt;
              if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
            end else begin
              btn_d = 8'h01 << target_q;
              if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPress: begin
          if (cnt_q == HoldLast) begin
            btn_d   = 8'h00;
            cnt_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            state_d = StWatch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOver: begin
          btn_d = 8'h00;
          if (done_q && auto_restart) begin
            state_d = StRestart;
            btn_d   = 8'h01;
            cnt_d   = '0;
          end else if (dp_in) begin
            state_d    = StWatch;
            valid_d    = 1'b0;
            mismatch_d = 1'b0;
          end else if (!done_q && (seg_in == prev_seg_q) && !(bad_q && (seg_in == pat_q))) begin
            // Decode only a pattern held for two cycles; a failed pattern is not retried
            // until the display changes.
            if (hex[4]) begin
              final_d    = hex[3:0];
              valid_d    = 1'b1;
              mismatch_d = (hex[3:0] != score_in[3:0]);
              done_d     = 1'b1;
              bad_d      = 1'b0;
            end else begin
              err_d = 1'b1;
              bad_d = 1'b1;
              pat_d = seg_in;
            end
          end
        end
        StRestart: begin
          if (cnt_q == HoldLast) btn_d = 8'h00;
          if (cnt_q == RestartLast) begin
            cnt_d      = '0;
            state_d    = StWatch;
            valid_d    = 1'b0;
            mismatch_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          btn_d   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      target_q   <= 3'd0;
      pat_q      <= 7'h7F;
      prev_seg_q <= 7'h7F;
      btn_q      <= 8'h00;
      hits_q     <= 8'h00;
      misses_q   <= 8'h00;
      final_q    <= 4'h0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      pat_q      <= pat_d;
      prev_seg_q <= seg_in;
      btn_q      <= btn_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      final_q    <= final_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
    end
  end

  assign btn_out        = btn_q;
  assign busy           = (state_q != StIdle);
  assign hits           = hits_q;
  assign misses         = misses_q;
  assign final_score    = final_q;
  assign score_valid    = valid_q;
  assign score_mismatch = mismatch_q;
  assign decode_err     = err_q;

endmodule

// File: tb/tb_mole_auto_player.sv
// Scoreboard bench for mole_auto_player: stimulus pushes expected presses and score
// decodes into queues; a negedge monitor pops them as the DUT presents button presses
// and score_valid rises.
module tb_mole_auto_player;

  logic       clk = 1'b0;
  logic       rst_n, en, dp_in, miss_en, auto_restart;
  logic [6:0] seg_in;
  logic [7:0] score_in;
  logic [7:0] btn_out, hits, misses;
  logic       busy, score_valid, score_mismatch, decode_err;
  logic [3:0] final_score;

  mole_auto_player #(
    .REACT_CYCLES(8),
    .HOLD_CYCLES (6),
    .GAP_CYCLES  (6),
    .CNT_W       (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .seg_in        (seg_in),
    .dp_in         (dp_in),
    .score_in      (score_in),
    .miss_en       (miss_en),
    .auto_restart  (auto_restart),
    .btn_out       (btn_out),
    .busy          (busy),
    .hits          (hits),
    .misses        (misses),
    .final_score   (final_score),
    .score_valid   (score_valid),
    .score_mismatch(score_mismatch),
    .decode_err    (decode_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] btn; int start; int width;} press_t;
  typedef struct {logic [3:0] digit; logic mism;} score_t;
  press_t press_q[$];
  score_t score_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_press(input logic [7:0] b, input int start, input int width);
    press_t p;
    p.btn = b; p.start = start; p.width = width;
    press_q.push_back(p);
  endtask

  task automatic exp_score(input logic [3:0] d, input logic m);
    score_t s;
    s.digit = d; s.mism = m;
    score_q.push_back(s);
  endtask

  // Monitor
  logic [7:0] prev_btn   = 8'h00;
  logic       prev_valid = 1'b0;
  press_t     cur;
  logic       cur_ok     = 1'b0;
  int         rise_cyc   = 0;
  int         err_seen   = 0;

  always @(negedge clk) begin
    if (decode_err === 1'b1) err_seen++;
    if (prev_btn == 8'h00 && btn_out != 8'h00) begin
      rise_cyc = cyc;
      if (press_q.size() == 0) begin
        checks++;
        errors++;
        cur_ok = 1'b0;
        $display("FAIL unexpected_press actual=%0h required=none", btn_out);
      end else begin
        cur    = press_q.pop_front();
        cur_ok = 1'b1;
        check("press_btn", btn_out, cur.btn);
        check("press_start", cyc, cur.start);
      end
    end else if (prev_btn != 8'h00 && btn_out == 8'h00 && cur_ok) begin
      check("press_width", cyc - rise_cyc, cur.width);
      cur_ok = 1'b0;
    end
    if (!prev_valid && score_valid === 1'b1) begin
      if (score_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_score actual=%0h required=none", final_score);
      end else begin
        score_t s;
        s = score_q.pop_front();
        check("final_score", final_score, s.digit);
        check("score_mismatch", score_mismatch, s.mism);
      end
    end
    prev_btn   = btn_out;
    prev_valid = score_valid;
  end

  initial begin
    int e0;
    int base;
    rst_n = 1'b0; en = 1'b1; dp_in = 1'b1; seg_in = 7'b1111011;
    score_in = 8'h00; miss_en = 1'b0; auto_restart = 1'b0;
    tick(3);
    check("rst_btn", btn_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_hits", hits, 8'h00);
    check("rst_misses", misses, 8'h00);
    check("rst_valid", score_valid, 1'b0);
    check("rst_final", final_score, 4'h0);
    check("rst_mism", score_mismatch, 1'b0);
    check("rst_err", decode_err, 1'b0);

    // Target 2 hit: IDLE->WATCH, WATCH->REACT, 8 REACT cycles.
    exp_press(8'h04, cyc + 10, 6);
    rst_n = 1'b1;
    tick(10); seg_in = 7'h7F; tick(14);
    check("hit_hits", hits, 8'd1);
    check("hit_misses", misses, 8'd0);
    check("hit_busy", busy, 1'b1);

    // Deliberate miss on target 2 and on target 6 (wraps to 0).
    seg_in = 7'b1111011; miss_en = 1'b1; exp_press(8'h08, cyc + 9, 6);
    tick(9); seg_in = 7'h7F; miss_en = 1'b0; tick(14);
    check("miss_misses", misses, 8'd1);
    check("miss_hits", hits, 8'd1);
    seg_in = 7'b0111111; miss_en = 1'b1; exp_press(8'h01, cyc + 9, 6);
    tick(9); seg_in = 7'h7F; miss_en = 1'b0; tick(14);
    check("miss6_misses", misses, 8'd2);

    // Target moves during REACT: abandon, retarget bit 5.
    seg_in = 7'b1111011; exp_press(8'h20, cyc + 14, 6);
    tick(4); seg_in = 7'b1011111; tick(10); seg_in = 7'h7F; tick(14);
    check("move_hits", hits, 8'd2);

    // Two segments lit while watching.
    e0 = err_seen;
    seg_in = 7'b1110011; tick(1); seg_in = 7'h7F; tick(2);
    check("watch_err_pulses", err_seen - e0, 1);

    // Game over, digit 5, matching then mismatching score.
    seg_in = 7'b0010010; dp_in = 1'b0; score_in = 8'h15; exp_score(4'h5, 1'b0);
    tick(4);
    check("over_valid", score_valid, 1'b1);
    dp_in = 1'b1; seg_in = 7'h7F; tick(2);
    check("over_valid_clear", score_valid, 1'b0);
    seg_in = 7'b0010010; dp_in = 1'b0; score_in = 8'h16; exp_score(4'h5, 1'b1);
    tick(4);
    check("over_mism", score_mismatch, 1'b1);
    dp_in = 1'b1; seg_in = 7'h7F; tick(2);

    // Illegal game-over pattern, then legal digit 0 with auto restart.
    e0 = err_seen;
    seg_in = 7'b1010101; dp_in = 1'b0; tick(6);
    check("bad_err_pulses", err_seen - e0, 1);
    check("bad_valid", score_valid, 1'b0);
    seg_in = 7'b1000000; score_in = 8'h00; auto_restart = 1'b1;
    exp_score(4'h0, 1'b0); exp_press(8'h01, cyc + 3, 6);
    tick(4); auto_restart = 1'b0; dp_in = 1'b1; seg_in = 7'h7F; tick(12);
    check("restart_valid_clear", score_valid, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_hits", hits, 8'd2);

    // en dropped mid-press.
    seg_in = 7'b1111011; exp_press(8'h04, cyc + 9, 3);
    tick(11); en = 1'b0; tick(1);
    check("en_btn", btn_out, 8'h00);
    check("en_busy", busy, 1'b0);
    check("en_hits", hits, 8'd3);
    seg_in = 7'h7F; en = 1'b1; tick(2);

    // Reset mid-press.
    seg_in = 7'b1111011; exp_press(8'h04, cyc + 9, 3);
    tick(11); rst_n = 1'b0; tick(1);
    check("mrst_btn", btn_out, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_hits", hits, 8'd0);
    check("mrst_misses", misses, 8'd0);

    // 300 back-to-back hits on target 0; period 1+8+6+6 = 21.
    seg_in = 7'b1111110;
    base = cyc;
    for (int i = 0; i < 300; i++) exp_press(8'h01, base + 10 + 21 * i, 6);
    rst_n = 1'b1;
    tick(10 + 21 * 299 + 2); seg_in = 7'h7F; tick(30);
    check("sat_hits", hits, 8'd255);
    check("sat_misses", misses, 8'd0);

    check("press_q_empty", press_q.size(), 0);
    check("score_q_empty", score_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
